// File: rtl/execute_stage.sv
// execute_stage: one-cycle ALU/shift/address execute with operand forwarding,
// plus an iterative 16-step shift-add multiplier that stalls upstream.
module execute_stage #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned MUL_STEPS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             condition_in,
    input  logic             LS_in,
    input  logic [15:0]      instruction_in,
    input  logic [WIDTH-1:0] op1_in,
    input  logic [WIDTH-1:0] op2_in,
    input  logic [3:0]       rd_reg1,
    input  logic [3:0]       rd_reg2,
    input  logic             fwd_wr,
    input  logic [3:0]       fwd_reg,
    input  logic [WIDTH-1:0] fwd_data,
    output logic [WIDTH-1:0] result_out,
    output logic [WIDTH-1:0] store_data_out,
    output logic [3:0]       wr_reg_out,
    output logic             wr_en_out,
    output logic             mem_read_out,
    output logic             mem_write_out,
    output logic             LS_out,
    output logic [15:0]      instruction_out,
    output logic             valid_out,
    output logic             zero_out,
    output logic             carry_out,
    output logic             stall_out
);

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned REG_W   = 4;
    localparam int unsigned OPC_W   = 4;
    localparam int unsigned PROD_W  = 2 * WIDTH;
    localparam int unsigned SH_W    = $clog2(WIDTH);
    localparam int unsigned CNT_W   = $clog2(MUL_STEPS) + 1;

    localparam logic [OPC_W-1:0] OP_ADD   = 4'h1;
    localparam logic [OPC_W-1:0] OP_SUB   = 4'h2;
    localparam logic [OPC_W-1:0] OP_AND   = 4'h3;
    localparam logic [OPC_W-1:0] OP_OR    = 4'h4;
    localparam logic [OPC_W-1:0] OP_XOR   = 4'h5;
    localparam logic [OPC_W-1:0] OP_SHL   = 4'h6;
    localparam logic [OPC_W-1:0] OP_SHR   = 4'h7;
    localparam logic [OPC_W-1:0] OP_MUL   = 4'h8;
    localparam logic [OPC_W-1:0] OP_LOAD  = 4'h9;
    localparam logic [OPC_W-1:0] OP_STORE = 4'hA;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   store_q, store_d;
    logic [REG_W-1:0]   wr_reg_q, wr_reg_d;
    logic               wr_en_q, wr_en_d;
    logic               mem_rd_q, mem_rd_d;
    logic               mem_wr_q, mem_wr_d;
    logic               ls_q, ls_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;

    logic [PROD_W-1:0]  mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [PROD_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [REG_W-1:0]   mul_rd_q, mul_rd_d;
    logic [INSTR_W-1:0] mul_instr_q, mul_instr_d;
    logic               mul_ls_q, mul_ls_d;

    logic [OPC_W-1:0]   opcode;
    logic [REG_W-1:0]   rd;
    logic               accept;
    logic               mul_done;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH:0]     sum_c;
    logic [PROD_W-1:0]  acc_step_c;

    assign opcode   = instruction_in[15:12];
    assign rd       = instruction_in[11:8];
    assign accept   = condition_in && (state_q == S_IDLE);
    assign mul_done = (cnt_q == CNT_W'(MUL_STEPS - 1));

    // Operand forwarding: own previous result first, then writeback port, then register file
    always_comb begin
        op_a = op1_in;
        if (wr_en_q && (wr_reg_q == rd_reg1)) begin
            op_a = result_q;
        end else if (fwd_wr && (fwd_reg == rd_reg1)) begin
            op_a = fwd_data;
        end
        op_b = op2_in;
        if (wr_en_q && (wr_reg_q == rd_reg2)) begin
            op_b = result_q;
        end else if (fwd_wr && (fwd_reg == rd_reg2)) begin
            op_b = fwd_data;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: enter MUL on an accepted multiply, leave after the last step
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && (opcode == OP_MUL)) state_d = S_MUL;
            S_MUL:   if (mul_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs and datapath next values
    always_comb begin
        result_d    = result_q;
        store_d     = store_q;
        wr_reg_d    = wr_reg_q;
        wr_en_d     = wr_en_q;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        ls_d        = ls_q;
        instr_d     = instr_q;
        valid_d     = 1'b0;
        zero_d      = zero_q;
        carry_d     = carry_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        mul_rd_d    = mul_rd_q;
        mul_instr_d = mul_instr_q;
        mul_ls_d    = mul_ls_q;
        sum_c       = {1'b0, op_a} + {1'b0, op_b};
        acc_step_c  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

        if (state_q == S_MUL) begin
            acc_d    = acc_step_c;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (mul_done) begin
                result_d = acc_step_c[WIDTH-1:0];
                carry_d  = |acc_step_c[PROD_W-1:WIDTH];
                zero_d   = (acc_step_c[WIDTH-1:0] == '0);
                valid_d  = 1'b1;
                wr_en_d  = 1'b1;
                wr_reg_d = mul_rd_q;
                instr_d  = mul_instr_q;
                ls_d     = mul_ls_q;
            end
        end else if (accept) begin
            if (opcode == OP_MUL) begin
                mcand_d     = PROD_W'(op_a);
                mplier_d    = op_b;
                acc_d       = '0;
                cnt_d       = '0;
                mul_rd_d    = rd;
                mul_instr_d = instruction_in;
                mul_ls_d    = LS_in;
            end else begin
                valid_d  = 1'b1;
                ls_d     = LS_in;
                instr_d  = instruction_in;
                wr_reg_d = rd;
                wr_en_d  = 1'b0;
                case (opcode)
                    OP_ADD: begin
                        result_d = sum_c[WIDTH-1:0];
                        carry_d  = sum_c[WIDTH];
                        zero_d   = (sum_c[WIDTH-1:0] == '0);
                        wr_en_d  = 1'b1;
                    end
                    OP_SUB: begin
                        result_d = op_a - op_b;
                        carry_d  = (op_a < op_b);
                        zero_d   = (op_a == op_b);
                        wr_en_d  = 1'b1;
                    end
                    OP_AND: begin
                        result_d = op_a & op_b;
                        carry_d  = 1'b0;
                        zero_d   = ((op_a & op_b) == '0);
                        wr_en_d  = 1'b1;
                    end
                    OP_OR: begin
                        result_d = op_a | op_b;
                        carry_d  = 1'b0;
                        zero_d   = ((op_a | op_b) == '0);
                        wr_en_d  = 1'b1;
                    end
                    OP_XOR: begin
                        result_d = op_a ^ op_b;
                        carry_d  = 1'b0;
                        zero_d   = ((op_a ^ op_b) == '0);
                        wr_en_d  = 1'b1;
                    end
                    OP_SHL: begin
                        result_d = op_a << op_b[SH_W-1:0];
                        carry_d  = 1'b0;
                        zero_d   = ((op_a << op_b[SH_W-1:0]) == '0);
                        wr_en_d  = 1'b1;
                    end
                    OP_SHR: begin
                        result_d = op_a >> op_b[SH_W-1:0];
                        carry_d  = 1'b0;
                        zero_d   = ((op_a >> op_b[SH_W-1:0]) == '0);
                        wr_en_d  = 1'b1;
                    end
                    OP_LOAD: begin
                        result_d = op_a;
                        mem_rd_d = 1'b1;
                        wr_en_d  = 1'b1;
                    end
                    OP_STORE: begin
                        result_d = op_a;
                        store_d  = op_b;
                        mem_wr_d = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q    <= '0;
            store_q     <= '0;
            wr_reg_q    <= '0;
            wr_en_q     <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            ls_q        <= 1'b0;
            instr_q     <= '0;
            valid_q     <= 1'b0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            mul_rd_q    <= '0;
            mul_instr_q <= '0;
            mul_ls_q    <= 1'b0;
        end else begin
            result_q    <= result_d;
            store_q     <= store_d;
            wr_reg_q    <= wr_reg_d;
            wr_en_q     <= wr_en_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            ls_q        <= ls_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            mul_rd_q    <= mul_rd_d;
            mul_instr_q <= mul_instr_d;
            mul_ls_q    <= mul_ls_d;
        end
    end

    assign result_out      = result_q;
    assign store_data_out  = store_q;
    assign wr_reg_out      = wr_reg_q;
    assign wr_en_out       = wr_en_q;
    assign mem_read_out    = mem_rd_q;
    assign mem_write_out   = mem_wr_q;
    assign LS_out          = ls_q;
    assign instruction_out = instr_q;
    assign valid_out       = valid_q;
    assign zero_out        = zero_q;
    assign carry_out       = carry_q;
    assign stall_out       = (state_q == S_MUL);

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed vector table, hand-written multi-cycle sequences
// and random instructions checked against a behavioural model.
module tb_execute_stage;

    logic        clk;
    logic        reset;
    logic        condition_in;
    logic        LS_in;
    logic [15:0] instruction_in;
    logic [15:0] op1_in;
    logic [15:0] op2_in;
    logic [3:0]  rd_reg1;
    logic [3:0]  rd_reg2;
    logic        fwd_wr;
    logic [3:0]  fwd_reg;
    logic [15:0] fwd_data;
    logic [15:0] result_out;
    logic [15:0] store_data_out;
    logic [3:0]  wr_reg_out;
    logic        wr_en_out;
    logic        mem_read_out;
    logic        mem_write_out;
    logic        LS_out;
    logic [15:0] instruction_out;
    logic        valid_out;
    logic        zero_out;
    logic        carry_out;
    logic        stall_out;

    execute_stage #(.WIDTH(16), .MUL_STEPS(16)) dut (
        .clk(clk), .reset(reset), .condition_in(condition_in), .LS_in(LS_in),
        .instruction_in(instruction_in), .op1_in(op1_in), .op2_in(op2_in),
        .rd_reg1(rd_reg1), .rd_reg2(rd_reg2), .fwd_wr(fwd_wr), .fwd_reg(fwd_reg),
        .fwd_data(fwd_data), .result_out(result_out), .store_data_out(store_data_out),
        .wr_reg_out(wr_reg_out), .wr_en_out(wr_en_out), .mem_read_out(mem_read_out),
        .mem_write_out(mem_write_out), .LS_out(LS_out), .instruction_out(instruction_out),
        .valid_out(valid_out), .zero_out(zero_out), .carry_out(carry_out),
        .stall_out(stall_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural view of the stage's visible state
    typedef struct {
        logic [15:0] result;
        logic [15:0] store;
        logic [3:0]  wr_reg;
        logic        wr_en;
        logic        zero;
        logic        carry;
        logic        ls;
        logic [15:0] instr;
    } mdl_t;

    typedef struct {
        logic [15:0] ins;
        logic [15:0] o1;
        logic [15:0] o2;
        logic [3:0]  r1;
        logic [3:0]  r2;
        logic        fw;
        logic [3:0]  fr;
        logic [15:0] fd;
        logic [15:0] exp_res;
        logic        exp_zero;
        logic        exp_carry;
        logic        exp_wr_en;
        logic        idle_after;
    } vec_t;

    mdl_t m;
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".result"}, 32'(result_out), 0);
        chk({tag, ".store"},  32'(store_data_out), 0);
        chk({tag, ".wr_reg"}, 32'(wr_reg_out), 0);
        chk({tag, ".wr_en"},  32'(wr_en_out), 0);
        chk({tag, ".mem_rd"}, 32'(mem_read_out), 0);
        chk({tag, ".mem_wr"}, 32'(mem_write_out), 0);
        chk({tag, ".ls"},     32'(LS_out), 0);
        chk({tag, ".instr"},  32'(instruction_out), 0);
        chk({tag, ".valid"},  32'(valid_out), 0);
        chk({tag, ".zero"},   32'(zero_out), 0);
        chk({tag, ".carry"},  32'(carry_out), 0);
        chk({tag, ".stall"},  32'(stall_out), 0);
    endtask

    // Idle cycles: nothing completes, architectural outputs hold
    task automatic idle_cycles(input int n, input string tag);
        condition_in = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, ".idle_valid"},  32'(valid_out), 0);
            chk({tag, ".idle_result"}, 32'(result_out), 32'(m.result));
            chk({tag, ".idle_wr_en"},  32'(wr_en_out), 32'(m.wr_en));
            chk({tag, ".idle_mem_rd"}, 32'(mem_read_out), 0);
            chk({tag, ".idle_mem_wr"}, 32'(mem_write_out), 0);
        end
    endtask

    // Issue one instruction at a negedge, wait for its completion, compare with the model
    task automatic run_instr(input string tag, input logic [15:0] ins, input logic [15:0] o1,
                             input logic [15:0] o2, input logic [3:0] r1, input logic [3:0] r2,
                             input logic fw, input logic [3:0] fr, input logic [15:0] fd,
                             input logic ls);
        logic [15:0] a, b, r;
        logic [3:0]  op;
        logic [31:0] wide;
        logic        exp_rd, exp_wr;
        int          stalls;
        mdl_t        e;

        op = ins[15:12];
        a  = (m.wr_en && m.wr_reg == r1) ? m.result : ((fw && fr == r1) ? fd : o1);
        b  = (m.wr_en && m.wr_reg == r2) ? m.result : ((fw && fr == r2) ? fd : o2);
        e        = m;
        e.wr_reg = ins[11:8];
        e.instr  = ins;
        e.ls     = ls;
        e.wr_en  = 1'b0;
        exp_rd   = 1'b0;
        exp_wr   = 1'b0;
        r        = 16'h0;
        case (op)
            4'h1: begin wide = 32'(a) + 32'(b); r = wide[15:0]; e.carry = (wide > 32'hFFFF); end
            4'h2: begin r = a - b; e.carry = (a < b); end
            4'h3: begin r = a & b; e.carry = 1'b0; end
            4'h4: begin r = a | b; e.carry = 1'b0; end
            4'h5: begin r = a ^ b; e.carry = 1'b0; end
            4'h6: begin r = 16'(32'(a) * (32'd1 << (b % 16))); e.carry = 1'b0; end
            4'h7: begin r = 16'(32'(a) / (32'd1 << (b % 16))); e.carry = 1'b0; end
            4'h8: begin wide = 32'(a) * 32'(b); r = wide[15:0]; e.carry = (wide > 32'hFFFF); end
            default: ;
        endcase
        if (op >= 4'h1 && op <= 4'h8) begin
            e.result = r;
            e.zero   = (r == 16'h0);
            e.wr_en  = 1'b1;
        end else if (op == 4'h9) begin
            e.result = a;
            e.wr_en  = 1'b1;
            exp_rd   = 1'b1;
        end else if (op == 4'hA) begin
            e.result = a;
            e.store  = b;
            exp_wr   = 1'b1;
        end

        condition_in   = 1'b1;
        instruction_in = ins;
        op1_in = o1; op2_in = o2; rd_reg1 = r1; rd_reg2 = r2;
        fwd_wr = fw; fwd_reg = fr; fwd_data = fd; LS_in = ls;
        @(posedge clk);
        @(negedge clk);
        if (op == 4'h8) begin
            stalls = 0;
            while (stall_out === 1'b1 && stalls < 40) begin
                stalls++;
                chk({tag, ".mul_busy_valid"}, 32'(valid_out), 0);
                @(negedge clk);
            end
            chk({tag, ".mul_stall_cycles"}, 32'(stalls), 32'd16);
        end
        chk({tag, ".stall"},  32'(stall_out), 0);
        chk({tag, ".valid"},  32'(valid_out), 1);
        chk({tag, ".result"}, 32'(result_out), 32'(e.result));
        chk({tag, ".store"},  32'(store_data_out), 32'(e.store));
        chk({tag, ".wr_reg"}, 32'(wr_reg_out), 32'(e.wr_reg));
        chk({tag, ".wr_en"},  32'(wr_en_out), 32'(e.wr_en));
        chk({tag, ".mem_rd"}, 32'(mem_read_out), 32'(exp_rd));
        chk({tag, ".mem_wr"}, 32'(mem_write_out), 32'(exp_wr));
        chk({tag, ".ls"},     32'(LS_out), 32'(e.ls));
        chk({tag, ".instr"},  32'(instruction_out), 32'(e.instr));
        chk({tag, ".zero"},   32'(zero_out), 32'(e.zero));
        chk({tag, ".carry"},  32'(carry_out), 32'(e.carry));
        m = e;
        condition_in = 1'b0;
        fwd_wr       = 1'b0;
    endtask

    vec_t tbl [13];

    initial begin
        tbl[0]  = '{16'h1712, 16'hFFFF, 16'h0001, 4'd1, 4'd2, 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{16'h1312, 16'h0005, 16'h0003, 4'd1, 4'd2, 1'b0, 4'd0, 16'h0000, 16'h0008, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{16'h2431, 16'h0000, 16'h0005, 4'd3, 4'd1, 1'b0, 4'd0, 16'h0000, 16'h0003, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{16'h2531, 16'h0000, 16'h0005, 4'd3, 4'd1, 1'b1, 4'd3, 16'h0010, 16'h000B, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{16'h2612, 16'h0003, 16'h0005, 4'd1, 4'd2, 1'b0, 4'd0, 16'h0000, 16'hFFFE, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{16'h9B12, 16'h1234, 16'h0000, 4'd1, 4'd2, 1'b0, 4'd0, 16'h0000, 16'h1234, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{16'hA012, 16'h0040, 16'hBEEF, 4'd1, 4'd2, 1'b0, 4'd0, 16'h0000, 16'h0040, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{16'h3612, 16'hF0F0, 16'hFF00, 4'd1, 4'd2, 1'b0, 4'd0, 16'h0000, 16'hF000, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{16'h4712, 16'h00F0, 16'h0F00, 4'd1, 4'd2, 1'b0, 4'd0, 16'h0000, 16'h0FF0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{16'h6912, 16'h8001, 16'h0011, 4'd1, 4'd2, 1'b0, 4'd0, 16'h0000, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{16'h7A12, 16'h8000, 16'h000F, 4'd1, 4'd2, 1'b0, 4'd0, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{16'h5812, 16'hAAAA, 16'hAAAA, 4'd1, 4'd2, 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[12] = '{16'hC012, 16'h1111, 16'h2222, 4'd1, 4'd2, 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};

        reset = 1'b1; condition_in = 1'b0; LS_in = 1'b0; instruction_in = 16'h0;
        op1_in = 16'h0; op2_in = 16'h0; rd_reg1 = 4'd0; rd_reg2 = 4'd0;
        fwd_wr = 1'b0; fwd_reg = 4'd0; fwd_data = 16'h0;
        m = '{default: '0};
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            run_instr(tag, tbl[i].ins, tbl[i].o1, tbl[i].o2, tbl[i].r1, tbl[i].r2,
                      tbl[i].fw, tbl[i].fr, tbl[i].fd, 1'b0);
            chk({tag, ".tbl_result"}, 32'(result_out), 32'(tbl[i].exp_res));
            chk({tag, ".tbl_zero"},   32'(zero_out), 32'(tbl[i].exp_zero));
            chk({tag, ".tbl_carry"},  32'(carry_out), 32'(tbl[i].exp_carry));
            chk({tag, ".tbl_wr_en"},  32'(wr_en_out), 32'(tbl[i].exp_wr_en));
            if (tbl[i].idle_after) idle_cycles(3, tag);
        end
        chk("vec6.tbl_store", 32'(m.store), 32'hBEEF);

        // MUL 0x0100 * 0x0101 followed by a held ADD forwarding the product
        run_instr("mul", 16'h8C12, 16'h0100, 16'h0101, 4'd1, 4'd2, 1'b0, 4'd0, 16'h0, 1'b1);
        chk("mul.result_const", 32'(result_out), 32'h0100);
        chk("mul.carry_const",  32'(carry_out), 1);
        run_instr("mul_add", 16'h1D1C, 16'h0001, 16'h0000, 4'd1, 4'd12, 1'b0, 4'd0, 16'h0, 1'b0);
        chk("mul_add.result_const", 32'(result_out), 32'h0101);

        // Reset in the middle of a MUL aborts it
        condition_in = 1'b1; instruction_in = 16'h8D12; op1_in = 16'h0007; op2_in = 16'h0009;
        rd_reg1 = 4'd1; rd_reg2 = 4'd2; LS_in = 1'b0;
        @(posedge clk);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("rst_mul.stall_before", 32'(stall_out), 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("rst_mul");
        reset = 1'b0;
        m = '{default: '0};
        idle_cycles(2, "rst_mul_after");
        run_instr("rst_add", 16'h1112, 16'h0022, 16'h0011, 4'd1, 4'd2, 1'b0, 4'd0, 16'h0, 1'b0);
        chk("rst_add.result_const", 32'(result_out), 32'h0033);

        // Random instruction stream against the model
        for (int i = 0; i < 300; i++) begin
            logic [15:0] ins, o1, o2, fd;
            ins = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
                   4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
            o1  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            o2  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 17)) : 16'($urandom);
            fd  = 16'($urandom);
            run_instr("rnd", ins, o1, o2, ins[7:4], ins[3:0], 1'($urandom_range(0, 1)),
                      4'($urandom_range(0, 3)), fd, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 7) == 0) idle_cycles(1, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage directly downstream of the register file.
- Consumes decoded operands, the instruction word, the condition (valid) bit and the load/store flag.
- Performs ALU, shift and address operations in one cycle; MUL takes 16 cycles through an iterative shift-add state machine and stalls upstream meanwhile.
- Applies operand forwarding from its own previous result and from the writeback port; the registered result feeds memory/writeback.

Parameters:
- WIDTH, 16, datapath/operand width.
- MUL_STEPS, 16, shift-add iterations per MUL (must equal WIDTH).

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- condition_in  input  1  instruction valid from register file
- LS_in  input  1  load/store instruction flag
- instruction_in  input  16  instruction word; [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2
- op1_in  input  16  rs1 value from register file
- op2_in  input  16  rs2 value from register file
- rd_reg1  input  4  rs1 index
- rd_reg2  input  4  rs2 index
- fwd_wr  input  1  writeback write enable
- fwd_reg  input  4  writeback destination index
- fwd_data  input  16  writeback data
- result_out  output  16  ALU result or memory address
- store_data_out  output  16  forwarded op2 for STORE
- wr_reg_out  output  4  destination register index
- wr_en_out  output  1  result must be written back
- mem_read_out  output  1  LOAD issued
- mem_write_out  output  1  STORE issued
- LS_out  output  1  registered LS_in
- instruction_out  output  16  registered instruction
- valid_out  output  1  outputs hold a completed instruction this cycle
- zero_out  output  1  result == 0 (ALU/MUL ops)
- carry_out  output  1  ADD carry / SUB borrow / MUL overflow
- stall_out  output  1  upstream must hold (combinational, = state==MUL)

Behaviour:

Reset:
- All outputs 0; FSM enters IDLE; multiplier registers cleared.
- Reset during MUL aborts it: no valid_out, stall_out 0 on the next cycle.

Accept:
- An instruction is accepted on a rising edge when condition_in=1 and stall_out=0.
- With no accept, valid_out=0 and all other outputs hold their values.

Forwarding (evaluated at accept, per operand independently):
- First priority: if wr_en_out=1 and wr_reg_out equals the operand index, use result_out.
- Otherwise, if fwd_wr=1 and fwd_reg equals the operand index, use fwd_data.
- Otherwise, use op1_in/op2_in.
- r0 is not special.

Opcodes (single-cycle; outputs registered at the accept edge, valid_out=1 for one cycle):
- 0 NOP: wr_en_out=0; flags unchanged.
- 1 ADD: a+b; carry = bit 16.
- 2 SUB: a-b; carry = borrow (a<b unsigned).
- 3 AND, 4 OR, 5 XOR: carry=0.
- 6 SHL: a << b[3:0]; 7 SHR: logical a >> b[3:0]; carry=0.
- 9 LOAD: result_out=a (address); mem_read_out=1; wr_en_out=1; flags unchanged.
- A STORE: result_out=a; store_data_out=b; mem_write_out=1; wr_en_out=0; flags unchanged.
- B-F: treated as NOP.
- wr_en_out=1 for opcodes 1-7, 9 and 8 (on completion); wr_reg_out=rd.
- mem_read_out and mem_write_out are 1 only in the valid_out cycle.

MUL (opcode 8), FSM IDLE -> MUL -> IDLE:
- Accept edge N: latch multiplicand, multiplier, rd and instruction; clear 32-bit accumulator and step counter; valid_out=0; stall_out=1 from this cycle.
- Each edge N+1..N+16: if multiplier LSB is 1, add shifted multiplicand; then shift.
- At edge N+16:
  - result_out = low 16 bits.
  - carry_out = OR of high 16 bits.
  - zero_out = (low 16 == 0).
  - valid_out=1, wr_en_out=1.
  - Return to IDLE; stall_out=0.
- Unsigned arithmetic, modulo 2^16.
- condition_in during MUL is ignored; upstream holds it.
- LS_out and instruction_out update at accept (single-cycle) or completion (MUL).

Test Plan:
- ADD, op1=0xFFFF, op2=0x0001 -> next cycle result_out=0x0000, zero_out=1, carry_out=1, valid_out=1, wr_en_out=1.
- Back-to-back ADD r3=r1+r2 (0x0005+0x0003) then SUB r4=r3-r1 with stale op1_in=0 -> second result 0x0003 (internal forward); repeat with fwd_wr=1, fwd_reg=3, fwd_data=0x0010 and no internal match -> 0x000B.
- MUL 0x0100 * 0x0101 -> stall_out high for exactly 16 cycles; result_out=0x0100, carry_out=1, valid_out pulses once at edge N+16; a held ADD is accepted on the next cycle.
- STORE op1=0x0040, op2=0xBEEF -> result_out=0x0040, store_data_out=0xBEEF, mem_write_out=1, wr_en_out=0, flags unchanged.
- reset asserted at MUL step 7 -> all outputs 0, stall_out 0 next cycle, no valid_out; a following ADD executes normally.
- condition_in=0 for 3 cycles after a valid XOR -> valid_out=0, result_out holds the XOR value; opcode 0xC -> valid_out=1, wr_en_out=0.
